// File: rtl/axi4_rd_master.sv
// AXI4 read-channel master: turns a one-shot user request into a single INCR
// burst on AR/R and hands each beat back to the user with a completion pulse.
module axi4_rd_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_start,
    input  logic [29:0] rd_addr,
    input  logic [7:0]  rd_len,
    output logic [63:0] rd_data,
    output logic        rd_done,
    output logic        rd_ready,
    output logic        m_axi_r_handshake,
    output logic [3:0]  m_axi_arid,
    output logic [29:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arlock,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic [3:0]  m_axi_arqos,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    state_e      state_q, state_d;
    logic        rd_start_d1_q;
    logic [29:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        start_pulse;
    logic        unused_rresp;

    assign start_pulse  = rd_start & ~rd_start_d1_q;
    assign unused_rresp = ^m_axi_rresp;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_start_d1_q <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
        end else begin
            state_q       <= state_d;
            rd_start_d1_q <= rd_start;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    araddr_d = rd_addr;
                    arlen_d  = rd_len;
                    state_d  = ADDR;
                end
            end
            ADDR: if (m_axi_arready) state_d = DATA;
            DATA: if (m_axi_rvalid && m_axi_rlast) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake controls decode straight from the registered state, so arvalid
    // has no combinational dependency on arready.
    always_comb begin
        m_axi_arvalid = (state_q == ADDR);
        m_axi_rready  = (state_q == DATA);
        rd_done       = (state_q == DONE);
        rd_ready      = (state_q == IDLE);
    end

    assign m_axi_r_handshake = m_axi_rvalid & m_axi_rready;
    assign rd_data           = m_axi_rdata;

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arid    = 4'd0;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0010;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

endmodule

// File: tb/tb_axi4_rd_master.sv
// Directed bench for axi4_rd_master: a table of burst scenarios driven through
// an inline slave model, with every expectation computed from the table.
module tb_axi4_rd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_start;
    logic [29:0] rd_addr;
    logic [7:0]  rd_len;
    logic [63:0] rd_data;
    logic        rd_done, rd_ready, m_axi_r_handshake;
    logic [3:0]  m_axi_arid;
    logic [29:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi4_rd_master dut (
        .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_data(rd_data), .rd_done(rd_done), .rd_ready(rd_ready),
        .m_axi_r_handshake(m_axi_r_handshake), .m_axi_arid(m_axi_arid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic [29:0] addr;
        logic [7:0]  len;
        int          idle_before;
        int          hold;        // cycles rd_start stays high
        int          ar_wait;     // cycles arvalid is stalled before arready
        int          gap;         // idle rvalid cycles before each beat
        bit          busy_start;  // extra rising edge of rd_start during the first beat
        int          abort_beat;  // beat index after which reset hits, -1 for none
    } vec_t;

    vec_t        vecs[7];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    int          hold_cyc;
    logic [63:0] next_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cyc >= hold_cyc) rd_start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        check({tag, "_rready"},  64'(m_axi_rready),  64'd0);
        check({tag, "_done"},    64'(rd_done),       64'd0);
        check({tag, "_ready"},   64'(rd_ready),      64'd1);
    endtask

    task automatic run_burst(input vec_t v);
        cyc      = 0;
        hold_cyc = v.hold;
        @(negedge clk);
        rd_start = 1'b1;
        rd_addr  = v.addr;
        rd_len   = v.len;
        #1;
        check("start_ready", 64'(rd_ready), 64'd1);

        for (int i = 0; i <= v.ar_wait; i++) begin
            tick();
            m_axi_arready = (i == v.ar_wait);
            #1;
            check("ar_valid",  64'(m_axi_arvalid), 64'd1);
            check("ar_addr",   64'(m_axi_araddr),  64'(v.addr));
            check("ar_len",    64'(m_axi_arlen),   64'(v.len));
            check("busy_ready", 64'(rd_ready),     64'd0);
        end
        check("ar_size",  64'(m_axi_arsize),  64'd3);
        check("ar_burst", 64'(m_axi_arburst), 64'd1);
        check("ar_cache", 64'(m_axi_arcache), 64'd2);

        for (int b = 0; b <= int'(v.len); b++) begin
            for (int g = 0; g < v.gap; g++) begin
                tick();
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axi_rdata   = 64'hDEAD_BEEF;
                #1;
                check("gap_hs",     64'(m_axi_r_handshake), 64'd0);
                check("gap_rready", 64'(m_axi_rready),      64'd1);
            end
            tick();
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b1;
            m_axi_rdata   = next_data;
            m_axi_rlast   = (b == int'(v.len));
            if (v.busy_start && b == 0) rd_start = 1'b1;
            #1;
            check("beat_hs",      64'(m_axi_r_handshake), 64'd1);
            check("beat_data",    rd_data,                next_data);
            check("beat_arvalid", 64'(m_axi_arvalid),     64'd0);
            check("beat_done",    64'(rd_done),           64'd0);
            next_data++;
            if (b == v.abort_beat) begin
                tick();
                m_axi_rlast = 1'b0;
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                check("abort_hs", 64'(m_axi_r_handshake), 64'd0);
                check("abort_araddr", 64'(m_axi_araddr), 64'd0);
                @(negedge clk);
                m_axi_rvalid = 1'b0;
                rst_n = 1'b1;
                return;
            end
        end

        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        check("done_pulse",  64'(rd_done),      64'd1);
        check("done_rready", 64'(m_axi_rready), 64'd0);
        check("done_ready",  64'(rd_ready),     64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            check_idle_outputs("post");
        end
    endtask

    initial begin
        vecs[0] = '{30'h8,         8'd2,   2,   3, 0, 0, 1'b0, -1};
        vecs[1] = '{30'h8,         8'd2,   300, 1, 0, 0, 1'b0, -1};
        vecs[2] = '{30'h100,       8'd3,   2,   1, 5, 2, 1'b0, -1};
        vecs[3] = '{30'h2000,      8'd2,   2,   1, 0, 0, 1'b1, -1};
        vecs[4] = '{30'h40,        8'd4,   2,   1, 0, 0, 1'b0, 1};
        vecs[5] = '{30'h3FFF_FFF8, 8'd0,   2,   1, 0, 0, 1'b0, -1};
        vecs[6] = '{30'h1000,      8'd255, 2,   1, 1, 0, 1'b0, -1};

        rst_n         = 1'b0;
        rd_start      = 1'b0;
        rd_addr       = 30'h155;
        rd_len        = 8'h7;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        next_data     = 64'd1;
        cyc           = 0;
        hold_cyc      = 1;

        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_araddr", 64'(m_axi_araddr), 64'd0);
        check("reset_arlen",  64'(m_axi_arlen),  64'd0);
        check("reset_arid",   64'(m_axi_arid),   64'd0);
        check("reset_arsize", 64'(m_axi_arsize), 64'd3);
        check("reset_arburst", 64'(m_axi_arburst), 64'd1);
        check("reset_arcache", 64'(m_axi_arcache), 64'd2);
        check("reset_misc", 64'({m_axi_arlock, m_axi_arprot, m_axi_arqos}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            repeat (vecs[i].idle_before) @(negedge clk);
            run_burst(vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
